// File: rtl/cl_axi_trace_cap.sv
// AXI bus trace capture: records handshake events into a circular buffer and
// stops a programmable number of entries after a trigger.
//
// state | meaning
// IDLE  | not capturing, buffer frozen, waiting for cfg_arm
// ARMED | recording every event cycle, looking for the trigger
// TRIG  | trigger seen, recording post-trigger entries until remain hits 0
// DONE  | capture complete, buffer frozen until re-armed
module cl_axi_trace_cap #(
  parameter int ADDR_W = 64,
  parameter int ID_W   = 16,
  parameter int DEPTH  = 1024,
  parameter int TS_W   = 32,
  localparam int PTR_W   = $clog2(DEPTH),
  localparam int ENTRY_W = TS_W + 2*ADDR_W + 4*ID_W + 11
) (
  input  logic               aclk,
  input  logic               aresetn,
  input  logic               mon_awvalid,
  input  logic               mon_awready,
  input  logic [ID_W-1:0]    mon_awid,
  input  logic [ADDR_W-1:0]  mon_awaddr,
  input  logic               mon_arvalid,
  input  logic               mon_arready,
  input  logic [ID_W-1:0]    mon_arid,
  input  logic [ADDR_W-1:0]  mon_araddr,
  input  logic               mon_wvalid,
  input  logic               mon_wready,
  input  logic               mon_wlast,
  input  logic               mon_rvalid,
  input  logic               mon_rready,
  input  logic               mon_rlast,
  input  logic [ID_W-1:0]    mon_rid,
  input  logic [1:0]         mon_rresp,
  input  logic               mon_bvalid,
  input  logic               mon_bready,
  input  logic [ID_W-1:0]    mon_bid,
  input  logic [1:0]         mon_bresp,
  input  logic               cfg_arm,
  input  logic               cfg_abort,
  input  logic [1:0]         cfg_trig_mode,
  input  logic [ADDR_W-1:0]  cfg_match_addr,
  input  logic [ADDR_W-1:0]  cfg_match_mask,
  input  logic [PTR_W-1:0]   cfg_post_cnt,
  input  logic               rd_en,
  input  logic [PTR_W-1:0]   rd_idx,
  output logic               rd_valid,
  output logic [ENTRY_W-1:0] rd_data,
  output logic [1:0]         sts_state,
  output logic [PTR_W-1:0]   sts_wr_ptr,
  output logic [PTR_W-1:0]   sts_trig_ptr,
  output logic               sts_wrapped,
  output logic               sts_done
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_TRIG  = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  state_e               state_q, state_d;
  logic [TS_W-1:0]      ts_q, ts_d;
  logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]     trig_ptr_q, trig_ptr_d;
  logic [PTR_W-1:0]     remain_q, remain_d;
  logic                 wrapped_q, wrapped_d;
  logic                 rd_valid_q, rd_valid_d;
  logic [ENTRY_W-1:0]   rd_data_q, rd_data_d;

  logic [ENTRY_W-1:0]   mem [DEPTH];

  logic                 hs_aw, hs_w, hs_ar, hs_r, hs_b;
  logic [4:0]           hs;
  logic                 event_cyc;
  logic                 aw_match, ar_match;
  logic                 trig_hit;
  logic                 wr_en;
  logic [ENTRY_W-1:0]   entry;

  always_comb begin
    hs_aw     = mon_awvalid & mon_awready;
    hs_w      = mon_wvalid  & mon_wready;
    hs_ar     = mon_arvalid & mon_arready;
    hs_r      = mon_rvalid  & mon_rready;
    hs_b      = mon_bvalid  & mon_bready;
    hs        = {hs_aw, hs_w, hs_ar, hs_r, hs_b};
    event_cyc = |hs;
    aw_match  = ((mon_awaddr ^ cfg_match_addr) & cfg_match_mask) == '0;
    ar_match  = ((mon_araddr ^ cfg_match_addr) & cfg_match_mask) == '0;
    trig_hit  = 1'b0;
    unique case (cfg_trig_mode)
      2'd0:    trig_hit = event_cyc;
      2'd1:    trig_hit = hs_aw & aw_match;
      2'd2:    trig_hit = hs_ar & ar_match;
      default: trig_hit = (hs_r & mon_rresp[1]) | (hs_b & mon_bresp[1]);
    endcase
    entry = {ts_q, hs, mon_awid, mon_awaddr, mon_arid, mon_araddr,
             mon_rid, mon_rresp, mon_rlast, mon_bid, mon_bresp, mon_wlast};
  end

  always_comb begin
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    trig_ptr_d = trig_ptr_q;
    wrapped_d  = wrapped_q;
    remain_d   = remain_q;
    wr_en      = 1'b0;
    ts_d       = ts_q + 1'b1;
    if (cfg_abort) begin
      state_d = ST_IDLE;
    end else begin
      unique case (state_q)
        ST_IDLE, ST_DONE: begin
          if (cfg_arm) begin
            state_d   = ST_ARMED;
            wr_ptr_d  = '0;
            wrapped_d = 1'b0;
          end
        end
        ST_ARMED: begin
          if (event_cyc) begin
            wr_en = 1'b1;
            if (trig_hit) begin
              trig_ptr_d = wr_ptr_q;
              // PTR_W-wide post count can never exceed DEPTH-1, so no clamp
              remain_d   = cfg_post_cnt;
              state_d    = (cfg_post_cnt == '0) ? ST_DONE : ST_TRIG;
            end
          end
        end
        ST_TRIG: begin
          if (event_cyc) begin
            wr_en    = 1'b1;
            remain_d = remain_q - 1'b1;
            if (remain_q == PTR_W'(1)) state_d = ST_DONE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
    if (wr_en) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
      if (&wr_ptr_q) wrapped_d = 1'b1;
    end
  end

  // Read-first: the registered read sees the memory before this cycle's write
  always_comb begin
    rd_valid_d = rd_en;
    rd_data_d  = rd_en ? mem[rd_idx] : rd_data_q;
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q    <= ST_IDLE;
      ts_q       <= '0;
      wr_ptr_q   <= '0;
      trig_ptr_q <= '0;
      remain_q   <= '0;
      wrapped_q  <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      ts_q       <= ts_d;
      wr_ptr_q   <= wr_ptr_d;
      trig_ptr_q <= trig_ptr_d;
      remain_q   <= remain_d;
      wrapped_q  <= wrapped_d;
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
    end
  end

  always_ff @(posedge aclk) begin
    if (wr_en) mem[wr_ptr_q] <= entry;
  end

  assign rd_valid     = rd_valid_q;
  assign rd_data      = rd_data_q;
  assign sts_state    = state_q;
  assign sts_wr_ptr   = wr_ptr_q;
  assign sts_trig_ptr = trig_ptr_q;
  assign sts_wrapped  = wrapped_q;
  assign sts_done     = (state_q == ST_DONE);

endmodule

// File: tb/tb_cl_axi_trace_cap.sv
// Bench for cl_axi_trace_cap: directed capture scenarios checked against a
// behavioural trace model every cycle, plus hand-computed literal checks.
module tb_cl_axi_trace_cap;
  localparam int AW = 32;
  localparam int IW = 8;
  localparam int D  = 16;
  localparam int TW = 16;
  localparam int PW = 4;
  localparam int EW = TW + 2*AW + 4*IW + 11;
  localparam int TS_LSB = EW - TW;
  localparam int HS_LSB = TS_LSB - 5;
  localparam int AWADDR_LSB = HS_LSB - IW - AW;

  logic aclk, aresetn;
  logic mon_awvalid, mon_awready, mon_arvalid, mon_arready;
  logic [IW-1:0] mon_awid, mon_arid, mon_rid, mon_bid;
  logic [AW-1:0] mon_awaddr, mon_araddr;
  logic mon_wvalid, mon_wready, mon_wlast;
  logic mon_rvalid, mon_rready, mon_rlast, mon_bvalid, mon_bready;
  logic [1:0] mon_rresp, mon_bresp;
  logic cfg_arm, cfg_abort;
  logic [1:0] cfg_trig_mode;
  logic [AW-1:0] cfg_match_addr, cfg_match_mask;
  logic [PW-1:0] cfg_post_cnt;
  logic rd_en;
  logic [PW-1:0] rd_idx;
  logic rd_valid;
  logic [EW-1:0] rd_data;
  logic [1:0] sts_state;
  logic [PW-1:0] sts_wr_ptr, sts_trig_ptr;
  logic sts_wrapped, sts_done;

  cl_axi_trace_cap #(.ADDR_W(AW), .ID_W(IW), .DEPTH(D), .TS_W(TW)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .mon_awvalid(mon_awvalid), .mon_awready(mon_awready), .mon_awid(mon_awid), .mon_awaddr(mon_awaddr),
    .mon_arvalid(mon_arvalid), .mon_arready(mon_arready), .mon_arid(mon_arid), .mon_araddr(mon_araddr),
    .mon_wvalid(mon_wvalid), .mon_wready(mon_wready), .mon_wlast(mon_wlast),
    .mon_rvalid(mon_rvalid), .mon_rready(mon_rready), .mon_rlast(mon_rlast), .mon_rid(mon_rid), .mon_rresp(mon_rresp),
    .mon_bvalid(mon_bvalid), .mon_bready(mon_bready), .mon_bid(mon_bid), .mon_bresp(mon_bresp),
    .cfg_arm(cfg_arm), .cfg_abort(cfg_abort), .cfg_trig_mode(cfg_trig_mode),
    .cfg_match_addr(cfg_match_addr), .cfg_match_mask(cfg_match_mask), .cfg_post_cnt(cfg_post_cnt),
    .rd_en(rd_en), .rd_idx(rd_idx), .rd_valid(rd_valid), .rd_data(rd_data),
    .sts_state(sts_state), .sts_wr_ptr(sts_wr_ptr), .sts_trig_ptr(sts_trig_ptr),
    .sts_wrapped(sts_wrapped), .sts_done(sts_done)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: capture phase, buffer contents, read port
  int            m_state = 0;
  logic [TW-1:0] m_ts = '0;
  int            m_wp = 0;
  int            m_tp = 0;
  bit            m_wrap = 0;
  bit            m_rv = 0;
  logic [EW-1:0] m_rd = '0;
  bit            m_rd_known = 1;
  logic [EW-1:0] m_mem [D];
  bit            m_known [D];
  int            post_goal = 0;
  int            post_seen = 0;

  function automatic logic [4:0] cur_hs();
    return {mon_awvalid & mon_awready, mon_wvalid & mon_wready, mon_arvalid & mon_arready,
            mon_rvalid & mon_rready, mon_bvalid & mon_bready};
  endfunction

  function automatic bit is_trig(input logic [4:0] h);
    case (cfg_trig_mode)
      2'd0: return h != 5'b0;
      2'd1: return h[4] && (((mon_awaddr ^ cfg_match_addr) & cfg_match_mask) == '0);
      2'd2: return h[2] && (((mon_araddr ^ cfg_match_addr) & cfg_match_mask) == '0);
      default: return (h[1] && mon_rresp[1]) || (h[0] && mon_bresp[1]);
    endcase
  endfunction

  always @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      m_state = 0; m_ts = '0; m_wp = 0; m_tp = 0; m_wrap = 0;
      m_rv = 0; m_rd = '0; m_rd_known = 1;
    end else begin
      logic [4:0] h;
      h = cur_hs();
      m_rv = rd_en;
      if (rd_en) begin
        m_rd = m_mem[rd_idx];
        m_rd_known = m_known[rd_idx];
      end
      if (cfg_abort) m_state = 0;
      else if (cfg_arm && (m_state == 0 || m_state == 3)) begin
        m_state = 1; m_wp = 0; m_wrap = 0;
      end else if (h != 5'b0 && (m_state == 1 || m_state == 2)) begin
        m_mem[m_wp] = {m_ts, h, mon_awid, mon_awaddr, mon_arid, mon_araddr, mon_rid, mon_rresp,
                       mon_rlast, mon_bid, mon_bresp, mon_wlast};
        m_known[m_wp] = 1;
        if (m_state == 1) begin
          if (is_trig(h)) begin
            m_tp = m_wp;
            post_goal = (int'(cfg_post_cnt) < D - 1) ? int'(cfg_post_cnt) : D - 1;
            post_seen = 0;
            m_state = (post_goal == 0) ? 3 : 2;
          end
        end else begin
          post_seen++;
          if (post_seen == post_goal) m_state = 3;
        end
        if (m_wp == D - 1) m_wrap = 1;
        m_wp = (m_wp + 1) % D;
      end
      m_ts = m_ts + 1'b1;
    end
  end

  always @(negedge aclk) begin
    chk("state", 256'(sts_state), 256'(m_state));
    chk("wr_ptr", 256'(sts_wr_ptr), 256'(m_wp));
    chk("trig_ptr", 256'(sts_trig_ptr), 256'(m_tp));
    chk("wrapped", 256'(sts_wrapped), 256'(m_wrap));
    chk("done", 256'(sts_done), 256'(m_state == 3));
    chk("rd_valid", 256'(rd_valid), 256'(m_rv));
    if (m_rv && m_rd_known) chk("rd_data", 256'(rd_data), 256'(m_rd));
  end

  task automatic cyc();
    @(posedge aclk);
    #1;
  endtask

  task automatic clr();
    mon_awvalid = 0; mon_awready = 0; mon_wvalid = 0; mon_wready = 0;
    mon_arvalid = 0; mon_arready = 0; mon_rvalid = 0; mon_rready = 0;
    mon_bvalid = 0; mon_bready = 0;
    cfg_arm = 0; cfg_abort = 0; rd_en = 0;
  endtask

  task automatic set_hs(input logic [4:0] h);
    mon_awvalid = h[4]; mon_awready = h[4];
    mon_wvalid  = h[3]; mon_wready  = h[3];
    mon_arvalid = h[2]; mon_arready = h[2];
    mon_rvalid  = h[1]; mon_rready  = h[1];
    mon_bvalid  = h[0]; mon_bready  = h[0];
  endtask

  task automatic step(input logic [4:0] h);
    set_hs(h); cyc(); clr();
  endtask

  task automatic arm();
    cfg_arm = 1; cyc(); clr();
  endtask

  task automatic rd(input int idx);
    rd_en = 1; rd_idx = PW'(idx); cyc(); clr();
  endtask

  logic [TW-1:0] ts0;

  initial begin
    clr();
    mon_awid = 8'h11; mon_arid = 8'h22; mon_rid = 8'h33; mon_bid = 8'h44;
    mon_awaddr = '0; mon_araddr = '0; mon_wlast = 1; mon_rlast = 1;
    mon_rresp = 2'b00; mon_bresp = 2'b00;
    cfg_trig_mode = 2'd0; cfg_match_addr = '0; cfg_match_mask = '0; cfg_post_cnt = '0;
    rd_idx = '0;
    aresetn = 1;
    #2 aresetn = 0;
    #1;
    chk("reset_state", 256'(sts_state), 256'(0));
    chk("reset_wr_ptr", 256'(sts_wr_ptr), 256'(0));
    chk("reset_rd_data", 256'(rd_data), 256'(0));
    repeat (2) @(posedge aclk);
    #1 aresetn = 1;
    cyc();

    // Mode 0, post 3: AW@t, W@t+2, AR+R@t+5, B@t+6
    cfg_trig_mode = 2'd0; cfg_post_cnt = 4'd3;
    arm();
    mon_awvalid = 1; cyc(); clr();
    chk("aw_no_ready", 256'(sts_wr_ptr), 256'(0));
    mon_awaddr = 32'h0000_0040;
    step(5'b10000);
    chk("a_trig_state", 256'(sts_state), 256'(2));
    step(5'b00000);
    step(5'b01000);
    step(5'b00000);
    step(5'b00000);
    step(5'b00110);
    chk("a_before_b", 256'(sts_state), 256'(2));
    step(5'b00001);
    chk("a_done_state", 256'(sts_state), 256'(3));
    chk("a_done_flag", 256'(sts_done), 256'(1));
    chk("a_wr_ptr", 256'(sts_wr_ptr), 256'(4));
    chk("a_trig_ptr", 256'(sts_trig_ptr), 256'(0));
    rd(0); ts0 = rd_data[TS_LSB +: TW];
    rd(1); chk("a_ts1", 256'(rd_data[TS_LSB +: TW] - ts0), 256'(2));
    rd(2); chk("a_hs2", 256'(rd_data[HS_LSB +: 5]), 256'(5'b00110));
    chk("a_ts2", 256'(rd_data[TS_LSB +: TW] - ts0), 256'(5));
    rd(3); chk("a_ts3", 256'(rd_data[TS_LSB +: TW] - ts0), 256'(6));

    // Mode 1 address match
    cfg_trig_mode = 2'd1; cfg_match_addr = 32'h0000_1000; cfg_match_mask = 32'hFFFF_F000;
    cfg_post_cnt = 4'd2;
    arm();
    mon_awaddr = 32'h0000_0800; step(5'b10000);
    chk("b_miss_state", 256'(sts_state), 256'(1));
    mon_awaddr = 32'h0000_1234; step(5'b10000);
    chk("b_trig_ptr", 256'(sts_trig_ptr), 256'(1));
    chk("b_trig_state", 256'(sts_state), 256'(2));
    step(5'b01000); step(5'b01000);
    chk("b_done", 256'(sts_state), 256'(3));

    // Mode 2 with post 0: straight to DONE
    cfg_trig_mode = 2'd2; cfg_post_cnt = 4'd0;
    arm();
    mon_araddr = 32'h0000_2000; step(5'b00100);
    chk("c_ar_miss", 256'(sts_state), 256'(1));
    mon_araddr = 32'h0000_1FFF; step(5'b00100);
    chk("c_post0_done", 256'(sts_state), 256'(3));
    chk("c_trig_ptr", 256'(sts_trig_ptr), 256'(1));

    // Mode 3: wrap before an error response
    cfg_trig_mode = 2'd3; cfg_post_cnt = 4'd1;
    mon_rresp = 2'b00; mon_bresp = 2'b01;
    arm();
    for (int i = 0; i < D + 5; i++) begin
      mon_awaddr = 32'(i);
      step((i % 2 == 0) ? 5'b00010 : 5'b00001);
      if (i == D - 2) chk("d_not_wrapped", 256'(sts_wrapped), 256'(0));
      if (i == D - 1) chk("d_wrapped_now", 256'(sts_wrapped), 256'(1));
    end
    chk("d_armed", 256'(sts_state), 256'(1));
    mon_bresp = 2'b10; step(5'b00001); mon_bresp = 2'b00;
    chk("d_trig_ptr", 256'(sts_trig_ptr), 256'(5));
    chk("d_wrapped", 256'(sts_wrapped), 256'(1));
    step(5'b01000);
    chk("d_done", 256'(sts_state), 256'(3));

    // Mode 0, maximum post count
    cfg_trig_mode = 2'd0; cfg_post_cnt = 4'(D - 1);
    arm();
    chk("e_wrap_clr", 256'(sts_wrapped), 256'(0));
    mon_awaddr = 32'hCAFE_0000; step(5'b10000);
    for (int k = 1; k < D; k++) begin
      mon_awaddr = 32'h100 + 32'(k);
      step(5'b10000);
      if (k == D - 2) chk("e_still_trig", 256'(sts_state), 256'(2));
    end
    chk("e_done", 256'(sts_state), 256'(3));
    chk("e_wr_ptr", 256'(sts_wr_ptr), 256'(0));
    mon_awaddr = 32'hDEAD_0000; step(5'b10000); step(5'b10000);
    chk("e_frozen", 256'(sts_wr_ptr), 256'(0));
    rd(0); chk("e_trig_kept", 256'(rd_data[AWADDR_LSB +: AW]), 256'(32'hCAFE_0000));

    // Arm and abort together from DONE
    cfg_arm = 1; cfg_abort = 1; cyc(); clr();
    chk("f_abort_idle", 256'(sts_state), 256'(0));
    step(5'b10000);
    chk("f_idle_frozen", 256'(sts_wr_ptr), 256'(0));
    rd(2);
    chk("f_rd_valid", 256'(rd_valid), 256'(1));
    chk("f_rd2", 256'(rd_data[AWADDR_LSB +: AW]), 256'(32'h102));
    cyc();
    chk("f_rd_valid_drop", 256'(rd_valid), 256'(0));

    // Read-first collision on index 0
    cfg_post_cnt = 4'd3;
    arm();
    mon_awaddr = 32'h5555_0000; set_hs(5'b10000); rd_en = 1; rd_idx = '0; cyc(); clr();
    chk("g_read_first", 256'(rd_data[AWADDR_LSB +: AW]), 256'(32'hCAFE_0000));
    rd(0); chk("g_new_entry", 256'(rd_data[AWADDR_LSB +: AW]), 256'(32'h5555_0000));

    // Reset mid-TRIG
    step(5'b01000);
    chk("h_in_trig", 256'(sts_state), 256'(2));
    #2 aresetn = 0;
    #1;
    chk("h_rst_state", 256'(sts_state), 256'(0));
    chk("h_rst_wr_ptr", 256'(sts_wr_ptr), 256'(0));
    chk("h_rst_trig_ptr", 256'(sts_trig_ptr), 256'(0));
    chk("h_rst_wrapped", 256'(sts_wrapped), 256'(0));
    chk("h_rst_done", 256'(sts_done), 256'(0));
    chk("h_rst_rd_valid", 256'(rd_valid), 256'(0));
    chk("h_rst_rd_data", 256'(rd_data), 256'(0));
    cyc(); cyc();
    aresetn = 1;
    cyc();
    step(5'b10000); step(5'b00001);
    chk("h_no_write", 256'(sts_wr_ptr), 256'(0));
    chk("h_idle", 256'(sts_state), 256'(0));
    arm();
    step(5'b10000);
    chk("h_rearm_write", 256'(sts_wr_ptr), 256'(1));
    chk("h_rearm_trig", 256'(sts_state), 256'(2));
    cyc();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
